// File: rtl/cnn_frame_streamer.sv
// -----------------------------------------------------------------------------
// cnn_frame_streamer
//
// Reads a stored image out of a single-port BRAM (1-cycle read latency) and
// replays it as a raster pixel stream with sensor-like timing:
//
//   start -> [start-up delay] -> vsync pulse -> [vsync delay] ->
//            line 0 -> [hsync gap] -> line 1 -> ... -> last line ->
//            drain (BRAM + output register) -> frame_done
//
// It feeds the CNN accelerator line buffers and doubles as the stimulus
// source for the accelerator datapath.
//
// Ports
//   HCLK, HRESETn        clock (rising edge), asynchronous active-low reset
//   start                one-cycle frame request, honoured only in IDLE
//   q_width, q_height    frame geometry, latched at start
//   q_start_up_delay     idle cycles between start and vsync, latched
//   q_hsync_delay        idle cycles between consecutive lines, latched
//   q_base_addr          BRAM word address of pixel (0,0), latched
//   sram_en, sram_addr   BRAM read port (registered)
//   sram_rdata           BRAM read data, valid the cycle after sram_en
//   out_pixel/out_valid  pixel stream; out_pixel is 0 whenever out_valid is 0
//   out_vsync            frame sync pulse, VSYNC_CYCLE cycles wide
//   out_line_last        qualifies out_valid: last pixel of a line
//   out_frame_last       qualifies out_valid: last pixel of the frame
//   busy                 high from the cycle after start until DONE inclusive
//   frame_done           one-cycle pulse right after the last out_valid
//   dbg_state            current FSM state, for observation only
//
// Stream handshake: out_valid is a pure valid with no ready. The consumer
// must accept out_pixel in every cycle out_valid is high; the side-band
// flags out_line_last/out_frame_last are meaningful only in those cycles
// and are forced to 0 otherwise.
// -----------------------------------------------------------------------------
module cnn_frame_streamer #(
   parameter int W_DATA      = 32,
   parameter int W_SIZE      = 12,
   parameter int W_DELAY     = 12,
   parameter int W_WORD      = 14,
   parameter int VSYNC_CYCLE = 3,
   parameter int VSYNC_DELAY = 3
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic                start,
   input  logic [W_SIZE-1:0]   q_width,
   input  logic [W_SIZE-1:0]   q_height,
   input  logic [W_DELAY-1:0]  q_start_up_delay,
   input  logic [W_DELAY-1:0]  q_hsync_delay,
   input  logic [W_WORD-1:0]   q_base_addr,
   output logic                sram_en,
   output logic [W_WORD-1:0]   sram_addr,
   input  logic [W_DATA-1:0]   sram_rdata,
   output logic [W_DATA-1:0]   out_pixel,
   output logic                out_valid,
   output logic                out_vsync,
   output logic                out_line_last,
   output logic                out_frame_last,
   output logic                busy,
   output logic                frame_done,
   output logic [2:0]          dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_STARTUP = 3'd1,
      S_VSYNC   = 3'd2,
      S_VDELAY  = 3'd3,
      S_LINE    = 3'd4,
      S_HGAP    = 3'd5,
      S_DRAIN   = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   // Sized constants keep every arithmetic/compare width-exact.
   localparam logic [W_SIZE-1:0]  SZ_ONE  = W_SIZE'(1);
   localparam logic [W_SIZE-1:0]  SZ_ZERO = '0;
   localparam logic [W_DELAY-1:0] DL_ONE  = W_DELAY'(1);
   localparam logic [W_DELAY-1:0] DL_ZERO = '0;
   localparam logic [W_WORD-1:0]  AD_ONE  = W_WORD'(1);
   // The delay counter counts up from 0; a timed state ends on its last value.
   localparam logic [W_DELAY-1:0] VS_LAST = W_DELAY'(VSYNC_CYCLE - 1);
   localparam logic [W_DELAY-1:0] VD_LAST = W_DELAY'(VSYNC_DELAY - 1);
   // DRAIN covers the BRAM read cycle plus the output register: it ends
   // when the counter reaches 1, so entering with 0 gives two cycles and
   // entering with 1 gives a single cycle (used by the zero-size frame).
   localparam logic [W_DELAY-1:0] DRAIN_LAST = W_DELAY'(1);

   // ---------------------------------------------------------------- state
   state_t              state_q,  state_d;
   logic [W_SIZE-1:0]   w_q,      w_d;
   logic [W_SIZE-1:0]   h_q,      h_d;
   logic [W_DELAY-1:0]  su_q,     su_d;
   logic [W_DELAY-1:0]  hd_q,     hd_d;
   logic [W_WORD-1:0]   base_q,   base_d;
   logic [W_SIZE-1:0]   col_q,    col_d;
   logic [W_SIZE-1:0]   row_q,    row_d;
   logic [W_DELAY-1:0]  dly_q,    dly_d;

   // ------------------------------------------------------ registered outputs
   logic                en_q,     en_d;
   logic [W_WORD-1:0]   addr_q,   addr_d;
   logic                vsync_q,  vsync_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;

   // ------------------------------------------------------- output pipeline
   // Stage 1 lines up with sram_rdata (cycle after the read was issued),
   // stage 2 is the output register.
   logic                valid_p1_q, valid_p1_d;
   logic                ll_p1_q,    ll_p1_d;
   logic                fl_p1_q,    fl_p1_d;
   logic                valid_q,    valid_d;
   logic [W_DATA-1:0]   pixel_q,    pixel_d;
   logic                ll_q,       ll_d;
   logic                fl_q,       fl_d;

   // Last-pixel decode for the read being issued this cycle.
   logic                line_last_now;
   logic                frame_last_now;

   always_comb begin
      line_last_now  = (col_q == (w_q - SZ_ONE));
      frame_last_now = line_last_now && (row_q == (h_q - SZ_ONE));
   end

   // -------------------------------------------------------- next-state logic
   // Outputs are computed from the transition being taken, so each one is
   // valid in the same cycle as the state it belongs to.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      h_d     = h_q;
      su_d    = su_q;
      hd_d    = hd_q;
      base_d  = base_q;
      col_d   = col_q;
      row_d   = row_q;
      dly_d   = dly_q;
      en_d    = 1'b0;
      addr_d  = addr_q;
      vsync_d = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ll_p1_d = 1'b0;
      fl_p1_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               w_d    = q_width;
               h_d    = q_height;
               su_d   = q_start_up_delay;
               hd_d   = q_hsync_delay;
               base_d = q_base_addr;
               col_d  = SZ_ZERO;
               row_d  = SZ_ZERO;
               dly_d  = DL_ZERO;
               busy_d = 1'b1;
               if ((q_width == SZ_ZERO) || (q_height == SZ_ZERO)) begin
                  // Empty frame: one drain cycle, then DONE. No vsync, no reads.
                  state_d = S_DRAIN;
                  dly_d   = DRAIN_LAST;
               end else if (q_start_up_delay == DL_ZERO) begin
                  state_d = S_VSYNC;
                  vsync_d = 1'b1;
               end else begin
                  state_d = S_STARTUP;
               end
            end
         end

         S_STARTUP: begin
            if (dly_q == (su_q - DL_ONE)) begin
               state_d = S_VSYNC;
               vsync_d = 1'b1;
               dly_d   = DL_ZERO;
            end else begin
               dly_d = dly_q + DL_ONE;
            end
         end

         S_VSYNC: begin
            if (dly_q == VS_LAST) begin
               dly_d = DL_ZERO;
               if (VSYNC_DELAY == 0) begin
                  state_d = S_LINE;
                  en_d    = 1'b1;
                  addr_d  = base_q;
               end else begin
                  state_d = S_VDELAY;
               end
            end else begin
               vsync_d = 1'b1;
               dly_d   = dly_q + DL_ONE;
            end
         end

         S_VDELAY: begin
            if (dly_q == VD_LAST) begin
               state_d = S_LINE;
               en_d    = 1'b1;
               addr_d  = base_q;
               dly_d   = DL_ZERO;
            end else begin
               dly_d = dly_q + DL_ONE;
            end
         end

         S_LINE: begin
            // Every LINE cycle issues exactly one read (sram_en_q is high);
            // its line/frame flags enter the pipeline alongside it.
            ll_p1_d = line_last_now;
            fl_p1_d = frame_last_now;
            if (!line_last_now) begin
               col_d  = col_q + SZ_ONE;
               en_d   = 1'b1;
               addr_d = addr_q + AD_ONE;
            end else begin
               col_d = SZ_ZERO;
               if (frame_last_now) begin
                  state_d = S_DRAIN;
                  dly_d   = DL_ZERO;
               end else begin
                  row_d = row_q + SZ_ONE;
                  if (hd_q == DL_ZERO) begin
                     // Back-to-back lines: the address just keeps counting.
                     en_d   = 1'b1;
                     addr_d = addr_q + AD_ONE;
                  end else begin
                     state_d = S_HGAP;
                     dly_d   = DL_ZERO;
                  end
               end
            end
         end

         S_HGAP: begin
            if (dly_q == (hd_q - DL_ONE)) begin
               state_d = S_LINE;
               en_d    = 1'b1;
               addr_d  = addr_q + AD_ONE;
               dly_d   = DL_ZERO;
            end else begin
               dly_d = dly_q + DL_ONE;
            end
         end

         S_DRAIN: begin
            if (dly_q == DRAIN_LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               dly_d   = DL_ZERO;
            end else begin
               dly_d = dly_q + DL_ONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------- output pipeline
   always_comb begin
      valid_p1_d = en_q;
      valid_d    = valid_p1_q;
      pixel_d    = valid_p1_q ? sram_rdata : '0;
      ll_d       = valid_p1_q & ll_p1_q;
      fl_d       = valid_p1_q & fl_p1_q;
   end

   // -------------------------------------------------------------- registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= S_IDLE;
         w_q        <= '0;
         h_q        <= '0;
         su_q       <= '0;
         hd_q       <= '0;
         base_q     <= '0;
         col_q      <= '0;
         row_q      <= '0;
         dly_q      <= '0;
         en_q       <= 1'b0;
         addr_q     <= '0;
         vsync_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         valid_p1_q <= 1'b0;
         ll_p1_q    <= 1'b0;
         fl_p1_q    <= 1'b0;
         valid_q    <= 1'b0;
         pixel_q    <= '0;
         ll_q       <= 1'b0;
         fl_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         w_q        <= w_d;
         h_q        <= h_d;
         su_q       <= su_d;
         hd_q       <= hd_d;
         base_q     <= base_d;
         col_q      <= col_d;
         row_q      <= row_d;
         dly_q      <= dly_d;
         en_q       <= en_d;
         addr_q     <= addr_d;
         vsync_q    <= vsync_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         valid_p1_q <= valid_p1_d;
         ll_p1_q    <= ll_p1_d;
         fl_p1_q    <= fl_p1_d;
         valid_q    <= valid_d;
         pixel_q    <= pixel_d;
         ll_q       <= ll_d;
         fl_q       <= fl_d;
      end
   end

   assign sram_en        = en_q;
   assign sram_addr      = addr_q;
   assign out_pixel      = pixel_q;
   assign out_valid      = valid_q;
   assign out_vsync      = vsync_q;
   assign out_line_last  = ll_q;
   assign out_frame_last = fl_q;
   assign busy           = busy_q;
   assign frame_done     = done_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// -----------------------------------------------------------------------------
// Bench for cnn_frame_streamer. A BRAM model with 1-cycle read latency holds
// random data. For every frame the expected per-cycle behaviour is computed
// from the frame timing rules with plain arithmetic (offset d from the start
// edge), and the expected pixel sequence is queued from the BRAM contents.
// -----------------------------------------------------------------------------
module tb_cnn_frame_streamer;

   localparam int W_DATA      = 32;
   localparam int W_SIZE      = 12;
   localparam int W_DELAY     = 12;
   localparam int W_WORD      = 14;
   localparam int VSYNC_CYCLE = 3;
   localparam int VSYNC_DELAY = 3;
   localparam int DEPTH       = 1 << W_WORD;

   logic                HCLK;
   logic                HRESETn;
   logic                start;
   logic [W_SIZE-1:0]   q_width;
   logic [W_SIZE-1:0]   q_height;
   logic [W_DELAY-1:0]  q_start_up_delay;
   logic [W_DELAY-1:0]  q_hsync_delay;
   logic [W_WORD-1:0]   q_base_addr;
   logic                sram_en;
   logic [W_WORD-1:0]   sram_addr;
   logic [W_DATA-1:0]   sram_rdata;
   logic [W_DATA-1:0]   out_pixel;
   logic                out_valid;
   logic                out_vsync;
   logic                out_line_last;
   logic                out_frame_last;
   logic                busy;
   logic                frame_done;
   logic [2:0]          dbg_state;

   cnn_frame_streamer dut (
      .HCLK             (HCLK),
      .HRESETn          (HRESETn),
      .start            (start),
      .q_width          (q_width),
      .q_height         (q_height),
      .q_start_up_delay (q_start_up_delay),
      .q_hsync_delay    (q_hsync_delay),
      .q_base_addr      (q_base_addr),
      .sram_en          (sram_en),
      .sram_addr        (sram_addr),
      .sram_rdata       (sram_rdata),
      .out_pixel        (out_pixel),
      .out_valid        (out_valid),
      .out_vsync        (out_vsync),
      .out_line_last    (out_line_last),
      .out_frame_last   (out_frame_last),
      .busy             (busy),
      .frame_done       (frame_done),
      .dbg_state        (dbg_state)
   );

   // ------------------------------------------------------- clock and reset
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // ------------------------------------------------------------ BRAM model
   logic [W_DATA-1:0] mem [DEPTH];

   always @(posedge HCLK) begin
      if (sram_en) sram_rdata <= mem[sram_addr];
   end

   // ------------------------------------------------------------ scoreboard
   int                n_checks;
   int                n_fail;
   logic [W_DATA-1:0] exp_q[$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // -------------------------------------------------------- reference model
   typedef struct packed {
      logic              en;
      logic [W_WORD-1:0] addr;
      logic              valid;
      logic              ll;
      logic              fl;
      logic              vs;
      logic              busy;
      logic              done;
   } exp_t;

   function automatic int done_offset(input int w, input int h, input int s, input int hd);
      int first;
      if (w == 0 || h == 0) return 1;
      first = s + VSYNC_CYCLE + VSYNC_DELAY;
      return first + (h - 1) * (w + hd) + (w - 1) + 3;
   endfunction

   // Expected outputs in cycle k+d, where start was sampled at edge k.
   function automatic exp_t model(input int d, input int w, input int h, input int s,
                                  input int hd, input int base);
      exp_t e;
      int   first, per, done_at, x, r, c;
      e = '0;
      done_at = done_offset(w, h, s, hd);
      e.busy  = (d <= done_at);
      e.done  = (d == done_at);
      if (w == 0 || h == 0) return e;
      first = s + VSYNC_CYCLE + VSYNC_DELAY;
      per   = w + hd;
      e.vs  = (d >= s) && (d < s + VSYNC_CYCLE);
      x = d - first;
      if (x >= 0) begin
         r = x / per;
         c = x % per;
         if (r < h && c < w) begin
            e.en   = 1'b1;
            e.addr = W_WORD'((base + r * w + c) % DEPTH);
         end
      end
      x = d - 2 - first;
      if (x >= 0) begin
         r = x / per;
         c = x % per;
         if (r < h && c < w) begin
            e.valid = 1'b1;
            e.ll    = (c == w - 1);
            e.fl    = (c == w - 1) && (r == h - 1);
         end
      end
      return e;
   endfunction

   function automatic logic [63:0] all_outputs();
      return {8'h0, dbg_state, sram_en, sram_addr, out_pixel, out_valid, out_vsync,
              out_line_last, out_frame_last, busy, frame_done};
   endfunction

   // ---------------------------------------------------------------- driver
   // Called at a falling edge. Requests a frame, then checks every cycle up
   // to and including the IDLE cycle after DONE. restart_at pulses start
   // during the frame (must be ignored); reset_at asserts HRESETn mid-frame.
   task automatic run_frame(input int w, input int h, input int s, input int hd,
                            input int base, input int restart_at, input int reset_at,
                            input string name);
      exp_t e;
      int   d_end;
      bit   aborted;
      aborted = 1'b0;
      d_end   = done_offset(w, h, s, hd) + 1;
      for (int i = 0; i < w * h; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
      q_width          = W_SIZE'(w);
      q_height         = W_SIZE'(h);
      q_start_up_delay = W_DELAY'(s);
      q_hsync_delay    = W_DELAY'(hd);
      q_base_addr      = W_WORD'(base);
      start            = 1'b1;
      @(posedge HCLK);
      #1;
      start            = 1'b0;
      // Config is latched; scrambling it now must not matter.
      q_width          = W_SIZE'($urandom_range(0, 4095));
      q_height         = W_SIZE'($urandom_range(0, 4095));
      q_start_up_delay = W_DELAY'($urandom_range(0, 4095));
      q_hsync_delay    = W_DELAY'($urandom_range(0, 4095));
      q_base_addr      = W_WORD'($urandom_range(0, DEPTH - 1));
      for (int d = 0; d <= d_end; d++) begin
         @(negedge HCLK);
         e = model(d, w, h, s, hd, base);
         check_val($sformatf("%s d=%0d sram_en", name, d), 64'(sram_en), 64'(e.en));
         if (e.en) check_val($sformatf("%s d=%0d sram_addr", name, d), 64'(sram_addr), 64'(e.addr));
         check_val($sformatf("%s d=%0d out_valid", name, d), 64'(out_valid), 64'(e.valid));
         check_val($sformatf("%s d=%0d line_last", name, d), 64'(out_line_last), 64'(e.ll));
         check_val($sformatf("%s d=%0d frame_last", name, d), 64'(out_frame_last), 64'(e.fl));
         check_val($sformatf("%s d=%0d vsync", name, d), 64'(out_vsync), 64'(e.vs));
         check_val($sformatf("%s d=%0d busy", name, d), 64'(busy), 64'(e.busy));
         check_val($sformatf("%s d=%0d frame_done", name, d), 64'(frame_done), 64'(e.done));
         if (out_valid) begin
            if (exp_q.size() == 0)
               check_val($sformatf("%s d=%0d extra_pixel", name, d), 64'(1), 64'(0));
            else
               check_val($sformatf("%s d=%0d pixel", name, d), 64'(out_pixel), 64'(exp_q.pop_front()));
         end else begin
            check_val($sformatf("%s d=%0d pixel_idle", name, d), 64'(out_pixel), 64'(0));
         end
         if (d == restart_at && d < d_end) begin
            start   = 1'b1;
            q_width = W_SIZE'(8);
         end else begin
            start = 1'b0;
         end
         if (d == reset_at) begin
            HRESETn = 1'b0;
            #1;
            check_val($sformatf("%s reset_immediate", name), all_outputs(), 64'(0));
            for (int i = 0; i < 3; i++) begin
               @(negedge HCLK);
               check_val($sformatf("%s reset_hold%0d", name, i), all_outputs(), 64'(0));
            end
            HRESETn = 1'b1;
            exp_q.delete();
            for (int i = 0; i < 4; i++) begin
               @(negedge HCLK);
               check_val($sformatf("%s post_reset%0d", name, i), all_outputs(), 64'(0));
            end
            aborted = 1'b1;
            break;
         end
      end
      if (!aborted) check_val($sformatf("%s pixels_left", name), 64'(exp_q.size()), 64'(0));
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge HCLK);
   endtask

   // --------------------------------------------------------------- stimulus
   initial begin
      int w, h, s, hd, base, rs;
      n_checks         = 0;
      n_fail           = 0;
      HRESETn          = 1'b0;
      start            = 1'b0;
      q_width          = '0;
      q_height         = '0;
      q_start_up_delay = '0;
      q_hsync_delay    = '0;
      q_base_addr      = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();

      idle_cycles(3);
      check_val("reset_state", all_outputs(), 64'(0));
      HRESETn = 1'b1;
      idle_cycles(2);
      check_val("idle_after_release", all_outputs(), 64'(0));

      run_frame(4, 2, 10, 5, 'h100, -1, -1, "s1_basic");
      // Back-to-back: this start is sampled at the end of the IDLE cycle.
      run_frame(3, 3, 0, 0, $urandom_range(0, DEPTH - 1), -1, -1, "s2_no_delay");
      idle_cycles(2);
      run_frame(0, 5, 7, 2, 'h200, -1, -1, "s3_zero_width");
      run_frame(6, 0, 0, 1, 'h210, -1, -1, "s3_zero_height");
      idle_cycles(1);
      run_frame(4, 2, 10, 5, 'h100, 19, -1, "s4_restart_ignored");
      run_frame(4, 1, $urandom_range(0, 5), $urandom_range(0, 4), DEPTH - 2, -1, -1, "s5_wrap");
      idle_cycles(3);
      run_frame(4, 2, 10, 5, 'h100, -1, 20, "s6_reset_mid");
      run_frame(4, 2, 10, 5, 'h100, -1, -1, "s6_after_reset");
      run_frame(1, 1, 0, 0, $urandom_range(0, DEPTH - 1), -1, -1, "one_pixel");

      for (int n = 0; n < 10; n++) begin
         w    = $urandom_range(1, 12);
         h    = $urandom_range(1, 5);
         s    = $urandom_range(0, 12);
         hd   = $urandom_range(0, 6);
         base = $urandom_range(0, DEPTH - 1);
         rs   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 25) : -1;
         run_frame(w, h, s, hd, base, rs, -1, $sformatf("rand%0d", n));
         idle_cycles($urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cnn_frame_streamer.md
Name: cnn_frame_streamer

Overview:
Transmit-side counterpart of bmp_image_writer. It reads a stored image from single-port BRAM (1-cycle read latency) and emits it as a raster pixel stream with sensor-style timing: start-up delay, vsync pulse, vsync delay, and a per-line hsync gap. It sits between the input-image BRAM and the CNN accelerator's line buffers, and also acts as the bench stimulus source for the accelerator datapath.

Parameters:
W_DATA, 32, pixel/BRAM word width
W_SIZE, 12, width/height field width
W_DELAY, 12, delay field width
W_WORD, 14, BRAM word address width
VSYNC_CYCLE, 3, cycles out_vsync is held high
VSYNC_DELAY, 3, cycles between vsync fall and first line read

Ports:
HCLK  in  1  clock, rising edge
HRESETn  in  1  asynchronous active-low reset
start  in  1  one-cycle frame start request
q_width  in  W_SIZE  pixels per line
q_height  in  W_SIZE  lines per frame
q_start_up_delay  in  W_DELAY  idle cycles before vsync
q_hsync_delay  in  W_DELAY  gap cycles between lines
q_base_addr  in  W_WORD  BRAM word address of pixel (0,0)
sram_en  out  1  BRAM read enable
sram_addr  out  W_WORD  BRAM read address
sram_rdata  in  W_DATA  BRAM read data, valid the cycle after sram_en
out_pixel  out  W_DATA  pixel data
out_valid  out  1  out_pixel valid
out_vsync  out  1  frame sync pulse
out_line_last  out  1  with out_valid: last pixel of a line
out_frame_last  out  1  with out_valid: last pixel of the frame
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Assertion mid-frame aborts immediately. No frame_done is pulsed. After release the block waits for a new start.
- FSM states: IDLE, STARTUP, VSYNC, VDELAY, LINE, HGAP, DRAIN, DONE.
- IDLE:
  - start=1 latches q_width, q_height, q_start_up_delay, q_hsync_delay and q_base_addr, and sets busy.
  - Next state is STARTUP, or VSYNC if q_start_up_delay=0.
  - In all other states start is ignored. Config input changes mid-frame have no effect.
- Timing, with start sampled at edge k and S = start-up delay:
  - STARTUP: cycles k..k+S-1.
  - VSYNC: VSYNC_CYCLE cycles with out_vsync=1.
  - VDELAY: VSYNC_DELAY cycles.
  - LINE: first read at cycle k+S+6 with default parameters.
- LINE:
  - sram_en=1 for exactly q_width consecutive cycles.
  - sram_addr starts at the latched base and increments by 1 per read, continuously across lines.
  - The address wraps modulo 2^W_WORD.
- HGAP: after a non-last line, exactly q_hsync_delay cycles with sram_en=0 (0 means back-to-back lines). Then LINE.
- Output pipeline:
  - A read issued in cycle t has rdata in t+1; the block registers it, so out_pixel/out_valid appear in cycle t+2.
  - out_pixel=0 whenever out_valid=0.
  - out_line_last and out_frame_last travel in the same pipeline and are 0 unless out_valid=1.
- After the last read: DRAIN for 2 cycles, then DONE. DONE is one cycle with frame_done=1 and busy=1; the next state is IDLE with busy=0.
  - frame_done therefore occurs in the cycle immediately after the last out_valid.
- A start sampled in the cycle IDLE is entered (after DONE) is accepted.
- Zero size: start with q_width=0 or q_height=0 goes IDLE -> DONE (frame_done next cycle) with no vsync, no reads and no pixels.
- Counters:
  - Column counter: W_SIZE bits. Row counter: W_SIZE bits. Delay counter: W_DELAY bits.
  - Pixel count is W_SIZE*2+1 bits and is not exposed.
  - Line and frame last are decoded from the column/row counters at read-issue time.

Test Plan:
1. W=4, H=2, S=10, HD=5, base=0x100, start at edge k:
   - out_vsync high k+10..k+12.
   - Reads 0x100..0x103 at k+16..k+19 and 0x104..0x107 at k+25..k+28.
   - out_valid k+18..k+21 and k+27..k+30.
   - out_line_last at k+21 and k+30; out_frame_last at k+30 only.
   - frame_done at k+31; busy low at k+32.
2. S=0, HD=0, W=3, H=3:
   - out_vsync at k..k+2.
   - 9 contiguous reads starting at k+6; 9 contiguous out_valid.
   - Pixels equal the BRAM contents in order.
3. W=0, H=5: frame_done at k+1; no sram_en, out_vsync or out_valid ever asserted.
4. start pulsed again at k+20 in scenario 1, with changed q_width=8: ignored; the frame is identical to scenario 1.
5. base=2^W_WORD-2, W=4, H=1: read addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
6. HRESETn low at k+20 during scenario 1:
   - All outputs 0 immediately; no frame_done.
   - A new start after release produces a full, correct frame.
